// File: rtl/pc_unit.sv
// Program counter for a single-cycle core: BOOT/RUN/HALT sequencing with branch and jump redirect.
// Define PC_PERF_CNT_EN to build the saturating redirect counter behind taken_cnt.
module pc_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Branch,
    input  logic        Jump,
    input  logic        Bne,
    input  logic        Zero,
    input  logic [31:0] imm_sext,
    input  logic [25:0] jaddr,
    input  logic        stall,
    input  logic        halt,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        fetch_valid,
    output logic        halted,
    output logic [31:0] taken_cnt
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic [31:0] w_pc_plus4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic        w_branch_taken;

    assign w_pc_plus4     = r_pc + 32'd4;
    assign w_br_tgt       = w_pc_plus4 + (imm_sext << 2);
    assign w_j_tgt        = {w_pc_plus4[31:28], jaddr, 2'b00};
    // control_single raises Branch alongside Jump, so Jump must mask the branch decision
    assign w_branch_taken = Branch & ~Jump & (Bne ? ~Zero : Zero);

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        case (r_state)
            ST_BOOT: begin
                // The boot slot consumes RESET_VEC; RUN begins at the following word
                w_state_nxt = ST_RUN;
                w_pc_nxt    = w_pc_plus4;
            end
            ST_RUN: begin
                if (halt) begin
                    w_state_nxt = ST_HALT;
                end else if (!stall) begin
                    if (Jump) begin
                        w_pc_nxt = w_j_tgt;
                    end else if (w_branch_taken) begin
                        w_pc_nxt = w_br_tgt;
                    end else begin
                        w_pc_nxt = w_pc_plus4;
                    end
                end
            end
            default: begin
                w_state_nxt = r_state;
                w_pc_nxt    = r_pc;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_VEC;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
        end
    end

    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_valid = (r_state == ST_RUN);
    assign halted      = (r_state == ST_HALT);

`ifdef PC_PERF_CNT_EN
    logic [31:0] r_taken_cnt;
    logic        w_redirect;

    assign w_redirect = (r_state == ST_RUN) & ~halt & ~stall & (Jump | w_branch_taken);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_taken_cnt <= 32'h0000_0000;
        end else if (w_redirect && (r_taken_cnt != 32'hFFFF_FFFF)) begin
            r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign taken_cnt = r_taken_cnt;
`else
    assign taken_cnt = 32'h0000_0000;
`endif

endmodule

// File: doc/pc_unit.md
PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 Parameter: RESET_VEC, 32'h0000_0000, PC value loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Branch  input  1  branch request from control_single.
REQ-005 Jump  input  1  jump request from control_single.
REQ-006 Bne  input  1  1 = branch on not-equal, 0 = branch on equal.
REQ-007 Zero  input  1  ALU zero flag for current instruction.
REQ-008 imm_sext  input  32  sign-extended 16-bit branch offset, in words.
REQ-009 jaddr  input  26  J-format target field.
REQ-010 stall  input  1  hold PC this cycle.
REQ-011 halt  input  1  stop fetching (unimplemented opcode or halt request).
REQ-012 pc  output  32  current PC / instruction-memory address.
REQ-013 pc_plus4  output  32  pc + 4, combinational.
REQ-014 fetch_valid  output  1  pc is a valid fetch address this cycle.
REQ-015 halted  output  1  unit is in HALT state.
REQ-016 taken_cnt  output  32  count of redirects (jumps plus taken branches).

Function
REQ-017 The state machine SHALL have states BOOT, RUN and HALT; reset enters BOOT.
REQ-018 BOOT SHALL last exactly one cycle with pc=RESET_VEC and fetch_valid=0, then go to RUN unconditionally.
REQ-019 In RUN, fetch_valid SHALL be 1; in BOOT and HALT it SHALL be 0.
REQ-020 RUN SHALL go to HALT on the edge where halt=1; HALT SHALL persist until reset.
REQ-021 pc_plus4 SHALL be pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-022 Branch target SHALL be pc_plus4 + (imm_sext<<2), modulo 2^32.
REQ-023 Jump target SHALL be {pc_plus4[31:28], jaddr, 2'b00}.
REQ-024 branch_taken SHALL equal Branch & ~Jump & (Bne ? ~Zero : Zero).
REQ-025 In RUN, next-PC priority SHALL be: halt (hold) > stall (hold) > Jump (jump target) > branch_taken (branch target) > pc_plus4.
REQ-026 Jump=1 with Branch=1 SHALL select the jump target, because control_single asserts Branch for J.
REQ-027 A redirect SHALL take effect on the next edge (one-cycle latency) with no delay slot.
REQ-028 stall and halt inputs SHALL be ignored in BOOT.
REQ-029 In HALT, pc SHALL hold its last value.
REQ-030 The redirect count SHALL increment by 1 on each RUN edge that takes a jump or a taken branch and is not stalled or halted.

Reset
REQ-031 On rst_n=0, the unit SHALL asynchronously set pc=RESET_VEC, state=BOOT, fetch_valid=0, halted=0 and taken_cnt=0.
REQ-032 Reset mid-operation, including during HALT or stall, SHALL override everything else.
REQ-033 After rst_n deasserts, the first rising edge SHALL move the unit from BOOT to RUN.

Configuration
REQ-034 With macro PC_PERF_CNT_EN defined, taken_cnt SHALL be a 32-bit register counting per REQ-030 and saturating at 32'hFFFF_FFFF.
REQ-035 With PC_PERF_CNT_EN undefined, taken_cnt SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-036 Reset release with RESET_VEC=0 and no control inputs -> pc sequence 0,0,4,8,C with fetch_valid 0,0,1,1,1.
REQ-037 Taken branch: pc=0x10, Branch=1, Bne=0, Zero=1, imm_sext=0xFFFF_FFFE -> next pc=0x0C and taken_cnt +1. The same stimulus with Zero=0 -> next pc=0x14 and no count change.
REQ-038 Jump over branch: pc=0x4000_0010, Jump=1, Branch=1, jaddr=0x0000040 -> next pc=0x4000_0100.
REQ-039 Stall, then halt: stall=1 for 3 cycles at pc=0x20 -> pc stays 0x20. halt=1 -> halted=1, fetch_valid=0 and pc frozen, even if Jump=1 afterwards.
REQ-040 Wrap-around: pc=0xFFFF_FFFC with no redirect -> next pc=0x0000_0000.
REQ-041 Counter saturation (with PC_PERF_CNT_EN): preload the count to 0xFFFF_FFFE and apply 3 jumps -> taken_cnt reads 0xFFFF_FFFF. rst_n pulsed low mid-cycle -> taken_cnt=0 and pc=RESET_VEC immediately.
